// File: rtl/complex_div.sv
// rtl/complex_div.sv - sequential complex divider z = a / b with shared multiplier and bit-serial dividers
module complex_div #(
  parameter int W     = 8,
  parameter int FRAC  = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     a_real,
  input  logic [W-1:0]     a_imag,
  input  logic [W-1:0]     b_real,
  input  logic [W-1:0]     b_imag,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] z_real,
  output logic [OUT_W-1:0] z_imag,
  output logic             div_by_zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int AW = 2*W + 1;          // accumulator width
  localparam int RW = AW + 1;           // shifted partial remainder width
  localparam int DW = 2*W + FRAC;       // dividend / quotient width
  localparam int CW = $clog2(DW + 1);
  localparam logic [DW-1:0] MAG_POS = DW'(2**(OUT_W-1) - 1);
  localparam logic [DW-1:0] MAG_NEG = DW'(2**(OUT_W-1));

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nx;

  logic signed [W-1:0]  ar, ai, br, bi;
  logic [2:0]           mul_cnt;
  logic [CW-1:0]        div_cnt;
  logic signed [AW-1:0] nre, nim;
  logic [AW-1:0]        den;
  logic [DW-1:0]        dvd_re, dvd_im, q_re, q_im;
  logic [AW-1:0]        rem_re, rem_im;
  logic                 neg_re, neg_im, dz;

  logic signed [W-1:0]   mx, my;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  prod_ext;
  logic [AW-1:0]         abs_re, abs_im;
  logic [RW-1:0]         rem_sh_re, rem_sh_im;
  logic                  fit_re, fit_im;

  assign in_ready = (state == IDLE);

  // Magnitude-to-signed conversion with saturation; the magnitude quotient
  // already truncates toward zero, so negation keeps that rounding.
  function automatic logic [OUT_W-1:0] sat(input logic [DW-1:0] q, input logic neg);
    if (!neg) sat = (q > MAG_POS) ? MAG_POS[OUT_W-1:0] : q[OUT_W-1:0];
    else      sat = (q > MAG_NEG) ? MAG_NEG[OUT_W-1:0] : OUT_W'(-q[OUT_W-1:0]);
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = MUL;
      MUL:  if (mul_cnt == 3'd5) state_nx = DIV;
      DIV:  if ((div_cnt == '0 && den == '0) || div_cnt == CW'(DW)) state_nx = DONE;
      DONE: if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shared multiplier operand selection in fixed product order.
  always_comb begin
    mx = '0;
    my = '0;
    case (mul_cnt)
      3'd0: begin mx = ar; my = br; end
      3'd1: begin mx = ai; my = bi; end
      3'd2: begin mx = ai; my = br; end
      3'd3: begin mx = ar; my = bi; end
      3'd4: begin mx = br; my = br; end
      3'd5: begin mx = bi; my = bi; end
      default: begin mx = '0; my = '0; end
    endcase
    prod     = mx * my;
    prod_ext = {prod[2*W-1], prod};
    abs_re   = nre[AW-1] ? AW'(-nre) : nre;
    abs_im   = nim[AW-1] ? AW'(-nim) : nim;
  end

  // One restoring-division step for each quotient component.
  always_comb begin
    rem_sh_re = {rem_re, dvd_re[DW-1]};
    rem_sh_im = {rem_im, dvd_im[DW-1]};
    fit_re    = rem_sh_re >= {1'b0, den};
    fit_im    = rem_sh_im >= {1'b0, den};
  end

  // Datapath: capture, multiply-accumulate, divide, and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar <= '0; ai <= '0; br <= '0; bi <= '0;
      mul_cnt <= '0; div_cnt <= '0;
      nre <= '0; nim <= '0; den <= '0;
      dvd_re <= '0; dvd_im <= '0; q_re <= '0; q_im <= '0;
      rem_re <= '0; rem_im <= '0;
      neg_re <= 1'b0; neg_im <= 1'b0; dz <= 1'b0;
      z_real <= '0; z_imag <= '0; div_by_zero <= 1'b0; out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ar <= a_real; ai <= a_imag; br <= b_real; bi <= b_imag;
            mul_cnt <= '0;
            div_cnt <= '0;
          end
        end
        MUL: begin
          case (mul_cnt)
            3'd0: nre <= prod_ext;
            3'd1: nre <= nre + prod_ext;
            3'd2: nim <= prod_ext;
            3'd3: nim <= nim - prod_ext;
            3'd4: den <= prod_ext;
            default: den <= den + prod_ext;
          endcase
          mul_cnt <= mul_cnt + 3'd1;
        end
        DIV: begin
          if (div_cnt == '0) begin
            dz     <= (den == '0);
            neg_re <= nre[AW-1];
            neg_im <= nim[AW-1];
            dvd_re <= DW'({abs_re, {FRAC{1'b0}}});
            dvd_im <= DW'({abs_im, {FRAC{1'b0}}});
            rem_re <= '0;
            rem_im <= '0;
            q_re   <= '0;
            q_im   <= '0;
          end else begin
            rem_re <= fit_re ? AW'(rem_sh_re - {1'b0, den}) : rem_sh_re[AW-1:0];
            rem_im <= fit_im ? AW'(rem_sh_im - {1'b0, den}) : rem_sh_im[AW-1:0];
            q_re   <= {q_re[DW-2:0], fit_re};
            q_im   <= {q_im[DW-2:0], fit_im};
            dvd_re <= dvd_re << 1;
            dvd_im <= dvd_im << 1;
          end
          div_cnt <= div_cnt + CW'(1);
        end
        DONE: begin
          // First DONE cycle publishes the result; afterwards hold until taken.
          if (!out_valid) begin
            z_real      <= dz ? '0 : sat(q_re, neg_re);
            z_imag      <= dz ? '0 : sat(q_im, neg_im);
            div_by_zero <= dz;
            out_valid   <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_div.sv
// tb/tb_complex_div.sv - scoreboard testbench for complex_div
module tb_complex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a_real, a_imag, b_real, b_imag;
  logic        in_valid, in_ready;
  logic [15:0] z_real, z_imag;
  logic        div_by_zero, out_valid, out_ready;

  always #5 clk = ~clk;

  complex_div dut (
    .clk(clk), .rst(rst),
    .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
    .in_valid(in_valid), .in_ready(in_ready),
    .z_real(z_real), .z_imag(z_imag), .div_by_zero(div_by_zero),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int qdiv(input int n, input int d);
    int m;
    m = ((n < 0) ? -n : n) * 256 / d;
    return sat16((n < 0) ? -m : m);
  endfunction

  function automatic exp_t model(input int ar, input int ai, input int br, input int bi);
    exp_t e;
    int nre, nim, den;
    nre = ar*br + ai*bi;
    nim = ai*br - ar*bi;
    den = br*br + bi*bi;
    if (den == 0) begin
      e.re = 16'd0; e.im = 16'd0; e.dz = 1'b1; e.lat = 8;
    end else begin
      e.re = 16'(qdiv(nre, den));
      e.im = 16'(qdiv(nim, den));
      e.dz = 1'b0; e.lat = 32;
    end
    return e;
  endfunction

  task automatic send_op(input logic signed [7:0] ar, input logic signed [7:0] ai,
                         input logic signed [7:0] br, input logic signed [7:0] bi);
    @(negedge clk);
    a_real = ar; a_imag = ai; b_real = br; b_imag = bi;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    sb.push_back(model(ar, ai, br, bi));
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_real = '0; a_imag = '0; b_real = '0; b_imag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || z_real !== 16'd0 ||
        z_imag !== 16'd0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b z=%0d,%0d dz=%b, required 1 0 0,0 0",
               in_ready, out_valid, z_real, z_imag, div_by_zero);
    end
  endtask

  task automatic test_directed();
    logic signed [7:0] tab [4][4];
    exp_t e;
    int cyc;
    tab[0] = '{8'sd3, 8'sd4, 8'sd1, 8'sd2};
    tab[1] = '{-8'sd5, 8'sd0, 8'sd0, 8'sd2};
    tab[2] = '{8'sd7, -8'sd3, 8'sd0, 8'sd0};
    tab[3] = '{-8'sd128, 8'sd0, -8'sd1, 8'sd0};
    for (int k = 0; k < 4; k++) begin
      send_op(tab[k][0], tab[k][1], tab[k][2], tab[k][3]);
      wait_result(cyc);
      e = sb.pop_front();
      n_tests++;
      if (cyc !== e.lat) begin
        n_fail++;
        $display("FAIL directed%0d latency: got %0d required %0d", k, cyc, e.lat);
      end
      n_tests++;
      if (z_real !== e.re || z_imag !== e.im || div_by_zero !== e.dz) begin
        n_fail++;
        $display("FAIL directed%0d result: got %0d,%0d dz=%b required %0d,%0d dz=%b", k,
                 $signed(z_real), $signed(z_imag), div_by_zero, $signed(e.re), $signed(e.im), e.dz);
      end
      consume();
      n_tests++;
      if (out_valid !== 1'b0 || z_real !== e.re || z_imag !== e.im) begin
        n_fail++;
        $display("FAIL directed%0d after_handshake: out_valid=%b z=%0d,%0d required 0 and held %0d,%0d",
                 k, out_valid, $signed(z_real), $signed(z_imag), $signed(e.re), $signed(e.im));
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int cyc;
    int bad;
    send_op(8'sd3, 8'sd4, 8'sd1, 8'sd2);
    wait_result(cyc);
    e = sb.pop_front();
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      in_valid = 1'b1;
      a_real = 8'($urandom_range(0, 255)); b_real = 8'($urandom_range(1, 127));
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || z_real !== e.re ||
          z_imag !== e.im || div_by_zero !== e.dz) begin
        n_fail++; bad++;
        if (bad < 3)
          $display("FAIL backpressure_hold: in_ready=%b out_valid=%b z=%0d,%0d required 0 1 %0d,%0d",
                   in_ready, out_valid, $signed(z_real), $signed(z_imag), $signed(e.re), $signed(e.im));
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_no_capture: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int cyc;
    send_op(8'sd3, 8'sd4, 8'sd1, 8'sd2);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || z_real !== 16'd0 ||
        z_imag !== 16'd0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: out_valid=%b in_ready=%b z=%0d,%0d dz=%b required 0 1 0,0 0",
               out_valid, in_ready, z_real, z_imag, div_by_zero);
    end
    send_op(-8'sd5, 8'sd0, 8'sd0, 8'sd2);
    wait_result(cyc);
    e = sb.pop_front();
    n_tests++;
    if (cyc !== e.lat || z_real !== e.re || z_imag !== e.im || div_by_zero !== e.dz) begin
      n_fail++;
      $display("FAIL reset_mid_fresh: lat=%0d z=%0d,%0d dz=%b required lat=%0d %0d,%0d dz=%b",
               cyc, $signed(z_real), $signed(z_imag), div_by_zero, e.lat,
               $signed(e.re), $signed(e.im), e.dz);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int cyc;
    logic [7:0] ar, ai, br, bi;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      ar = 8'($urandom_range(0, 255));
      ai = 8'($urandom_range(0, 255));
      br = 8'($urandom_range(0, 255));
      bi = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) begin br = '0; bi = '0; end
      if (k == 0) begin ar = 8'h80; ai = 8'h80; br = 8'h01; bi = 8'h00; end
      send_op(ar, ai, br, bi);
      wait_result(cyc);
      e = sb.pop_front();
      n_tests++;
      if (cyc !== e.lat || z_real !== e.re || z_imag !== e.im || div_by_zero !== e.dz) begin
        n_fail++;
        $display("FAIL b2b%0d a=%0d,%0d b=%0d,%0d: lat=%0d z=%0d,%0d dz=%b required lat=%0d %0d,%0d dz=%b",
                 k, $signed(ar), $signed(ai), $signed(br), $signed(bi), cyc,
                 $signed(z_real), $signed(z_imag), div_by_zero, e.lat,
                 $signed(e.re), $signed(e.im), e.dz);
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
